hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, performance counter width.
REQ-002 Parameter: MEM_TIMEOUT, default 15, maximum consecutive wait cycles before error.
REQ-003 clk  in  1  pipeline clock; state updates on negedge, aligned with the pipeline registers.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  EX instruction is a load.
REQ-009 branch_taken  in  1  EX resolved a taken branch this cycle.
REQ-010 dmem_req, dmem_ready  in  1 each  data-memory request from MEM and completion from memory.
REQ-011 pc_write, if_id_write, id_ex_write  out  1 each  load enables for PC, IF/ID and ID/EX.
REQ-012 if_id_flush, id_ex_flush  out  1 each  bubble insert; flush forces zero control fields.
REQ-013 ex_mem_hold  out  1  freezes EX/MEM and MEM stage.
REQ-014 state  out  2  current FSM state.
REQ-015 timeout_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  performance counters.

Function
REQ-017 FSM states SHALL be RUN=0, MEM_WAIT=1, ERROR=2; encoding 3 is unused and SHALL return to RUN.
REQ-018 All enable and flush outputs SHALL be combinational from state and inputs (zero-cycle latency); state and counters SHALL be registered.
REQ-019 Load-use hazard = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
REQ-020 In RUN with no event: pc_write=if_id_write=id_ex_write=1; all flush/hold outputs 0.
REQ-021 In RUN with dmem_req && !dmem_ready: pc_write=if_id_write=id_ex_write=0, ex_mem_hold=1, no flush; next state MEM_WAIT; wait counter loaded with 1.
REQ-022 In RUN with taken branch (and no memory stall): if_id_flush=id_ex_flush=1, pc_write=1; state stays RUN.
REQ-023 In RUN with load-use (and no memory stall or branch): pc_write=if_id_write=0, id_ex_flush=1, id_ex_write=1; a single-cycle stall that re-evaluates on the next cycle.
REQ-024 Priority SHALL be memory stall > taken branch > load-use; a simultaneous branch and load-use SHALL produce only the branch flush.
REQ-025 In MEM_WAIT with !dmem_ready: full freeze as in REQ-021; branch_taken and load-use are ignored; the wait counter increments.
REQ-026 In MEM_WAIT with dmem_ready: outputs as in RUN for the current inputs (the branch and load-use rules apply that cycle); next state RUN.
REQ-027 When the wait counter reaches MEM_TIMEOUT while still !dmem_ready, the FSM SHALL go to ERROR and set timeout_err.
REQ-028 ERROR is terminal until reset: full freeze, no flush, timeout_err=1.
REQ-029 dmem_req && dmem_ready in the same RUN cycle SHALL cause no stall.

Reset
REQ-030 Reset SHALL force state=RUN, timeout_err=0, wait counter=0 and all performance counters=0; outputs then follow RUN rules.
REQ-031 Reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the wait immediately, with no residual hold after release.

Configuration
REQ-032 With macro HAZARD_PERF_CNT_EN defined: per cycle, stall_cnt counts load-use stalls, flush_cnt counts branch flushes and wait_cnt counts freeze cycles; all saturate at 2^CNT_W-1.
REQ-033 Without HAZARD_PERF_CNT_EN: the counter ports remain present and are driven constant 0, and no counter flops exist.

Structure
REQ-034 Package pipe_ctrl_pkg SHALL hold the state enum, the state encodings and the default MEM_TIMEOUT constant.
REQ-035 Sub-module sat_counter (parameter width, inc, clear, saturating) SHALL be instantiated three times under the macro.

Verification
REQ-036 ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1.
REQ-037 ex_rd=0 with a load and id_rs1=0 -> no stall.
REQ-038 branch_taken=1 with a load-use hazard in the same cycle -> if_id_flush=id_ex_flush=1, pc_write=1, stall_cnt unchanged.
REQ-039 dmem_req=1 and dmem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles, return to RUN, wait_cnt=3.
REQ-040 dmem_ready held 0 with MEM_TIMEOUT=15 -> state=ERROR after 15 wait cycles, timeout_err=1 until reset; reset asserted -> RUN immediately.
REQ-041 Build without HAZARD_PERF_CNT_EN, rerun REQ-036 -> stall_cnt stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encoding and defaults shared by the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int DEFAULT_MEM_TIMEOUT = 15;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter clocked with the pipeline registers (negedge)
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze controller with memory-wait timeout
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              load_use;
  logic              freeze;
  logic              run_rules;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    freeze      = 1'b0;
    run_rules   = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze  = 1'b1;
          wait_d  = WAIT_W'(1);
          state_d = (MEM_TIMEOUT <= 1) ? ST_ERROR : ST_MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          freeze = 1'b1;
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d >= TIMEOUT_V) state_d = ST_ERROR;
        end else begin
          run_rules = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_ERROR: freeze = 1'b1;
      default:  state_d = ST_RUN;
    endcase

    // Memory freeze beats everything; a taken branch squashes any load-use stall.
    if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
    end else if (run_rules) begin
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == ST_ERROR) timeout_err <= 1'b1;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_ev, flush_ev, wait_ev;

  // A lone ID/EX bubble only arises from a load-use stall.
  assign stall_ev = id_ex_flush && !if_id_flush;
  assign flush_ev = if_id_flush;
  assign wait_ev  = ex_mem_hold;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_ev), .clear(1'b0), .count(stall_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_ev), .clear(1'b0), .count(flush_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk(clk), .reset(reset), .inc(wait_ev), .clear(1'b0), .count(wait_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule
